// File: rtl/sw_debounce_leds.sv
// Switch synchroniser/debouncer driving registered LED gates, event and press counter.
// Optional heartbeat divider enabled by defining HEARTBEAT_EN.
module sw_debounce_leds #(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 4,
    parameter int BLINK_DIV_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic              cnt_clr,
    output logic [NUM_SW-1:0] led_sw,
    output logic              led_and,
    output logic              led_or,
    output logic              led_xor,
    output logic              led_event,
    output logic [CNT_W-1:0]  led_cnt,
    output logic              led_heartbeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_stable;
    logic [NUM_SW-1:0] r_stable_q;
    logic [DW-1:0]     r_dcnt [NUM_SW];
    logic              r_and;
    logic              r_or;
    logic              r_xor;
    logic              r_event;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            // A non-zero count means this channel is pending a new level.
            for (int i = 0; i < NUM_SW; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DC_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_dcnt[i]   <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable[0] & ~r_stable_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_q <= '0;
            r_and      <= 1'b0;
            r_or       <= 1'b0;
            r_xor      <= 1'b0;
            r_event    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_stable_q <= r_stable;
            r_and      <= &r_stable;
            r_or       <= |r_stable;
            r_xor      <= ^r_stable;
            r_event    <= |(r_stable ^ r_stable_q);
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef HEARTBEAT_EN
    logic [BLINK_DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign led_heartbeat = r_div[BLINK_DIV_W-1];
`else
    // Width only matters with the divider; this is constant 0.
    assign led_heartbeat = (BLINK_DIV_W < 0);
`endif

    assign led_sw    = r_stable;
    assign led_and   = r_and;
    assign led_or    = r_or;
    assign led_xor   = r_xor;
    assign led_event = r_event;
    assign led_cnt   = r_cnt;

endmodule

// File: doc/sw_debounce_leds.md
Name: sw_debounce_leds

Overview:
Parametrised successor to the two-switch/LED logic demo. It takes NUM_SW raw board switches and, per channel, synchronises and debounces them. It drives registered LED outputs: the debounced switch states, AND/OR/XOR reductions, a change-event pulse and a wrapping press counter. It sits between board switch pins and the LED pins at the FPGA top level.

Parameters:
NUM_SW, 2, number of switch channels (>=1)
DEBOUNCE_CYCLES, 1000, consecutive cycles a new synchronised level must persist before it is accepted (>=1)
CNT_W, 4, width of press counter shown on led_cnt
BLINK_DIV_W, 24, heartbeat divider width (used only with the optional feature)

Ports:
clk  in  1  system clock; all state rising-edge
rst_n  in  1  asynchronous, active-low reset
sw  in  NUM_SW  raw switch inputs, asynchronous to clk
cnt_clr  in  1  synchronous clear of press counter
led_sw  out  NUM_SW  debounced switch states
led_and  out  1  AND of all debounced switches
led_or  out  1  OR of all debounced switches
led_xor  out  1  XOR (parity) of all debounced switches
led_event  out  1  one-cycle pulse when any debounced bit changes
led_cnt  out  CNT_W  count of rising edges of debounced sw[0]
led_heartbeat  out  1  heartbeat blink (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, stable states, debounce counters, press counter, divider and every output go to 0.
- Synchroniser: 2-flop chain per channel; sync[i] is sw[i] delayed 2 edges.
- Debounce, per channel, independent counter dcnt of width clog2(DEBOUNCE_CYCLES+1):
  - sync == stable: dcnt <= 0.
  - sync != stable and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - sync != stable and dcnt == DEBOUNCE_CYCLES-1: stable <= sync and dcnt <= 0.
  - A glitch that returns before acceptance clears dcnt; a later change restarts the full count.
- Latency: a clean input change is reflected in stable on the (2+DEBOUNCE_CYCLES)th rising edge after it. DEBOUNCE_CYCLES=1 gives 3 edges.
- led_sw == stable, with no extra register.
- led_and, led_or and led_xor are registered from stable and update 1 edge after stable.
- led_event is registered: 1 for exactly one cycle, aligned with the gate outputs, when stable differs from its previous value. Simultaneous changes on several channels give one pulse.
- Press counter: increments on the edge after stable[0] goes 0->1, aligned with led_event.
  - Wraps from 2^CNT_W-1 to 0.
  - cnt_clr has priority over increment; a coincident rise is lost.
  - Falling edges do not count.
- Switch high through reset release: stable starts at 0, so after the debounce latency it rises and counts 1. This is required behaviour.
- Reset asserted mid-debounce discards partial counts. There are no other state machines; the per-channel debounce is a two-state (stable / pending) machine encoded by dcnt != 0.

Optional Feature:
Macro HEARTBEAT_EN.
- Defined: free-running BLINK_DIV_W-bit counter, reset 0; led_heartbeat = counter MSB. Period 2^BLINK_DIV_W cycles, 50% duty.
- Undefined: no divider logic; led_heartbeat tied to 0. The port is still present so benches and tops are unchanged.

Test Plan:
All scenarios use NUM_SW=2, DEBOUNCE_CYCLES=4, CNT_W=4.
1. Reset, then sw=00 held 20 cycles -> all outputs 0, led_event never pulses.
2. Step the inputs cleanly, holding each for 20 cycles: 00 -> 01 -> 10 -> 11.
   - Rows, as and/or/xor: 01 -> 0/1/1, 10 -> 0/1/1, 11 -> 1/1/0.
   - led_sw changes on edge 6 after each step; the gates and one led_event pulse follow on edge 7.
   - led_cnt reaches 1 after the 01 step and 2 after the 11 step (rising sw[0] at 00->01 and 10->11).
3. Set sw[0]=1 for 3 cycles, then 0 (a glitch) -> led_sw[0] stays 0, no led_event, led_cnt unchanged. Then set sw[0]=1 for 4+ cycles -> accepted on edge 6.
4. Toggle sw[0] cleanly 17 times high -> led_cnt goes 15 -> 0 on the 16th rise and reads 1 after the 17th. Assert cnt_clr on the same edge as a rise -> led_cnt=0.
5. Drive sw=11 while rst_n is low, then release -> led_sw=11 on edge 6 after release, one led_event, led_cnt=1. Pulse rst_n low mid-debounce -> outputs 0 immediately and asynchronously.
6. HEARTBEAT_EN defined with BLINK_DIV_W=3 -> led_heartbeat toggles every 4 cycles. Macro undefined -> led_heartbeat constant 0.
